get_put_link_fifo: RTL and testbench
====================================

Name: get_put_link_fifo

Overview:
Parametrised, buffered link between a BSV-style Put method (EN_put/RDY_put/put) and a Get method (EN_get/RDY_get/get). It replaces the purely combinational put-to-get wire with a DEPTH-entry register FIFO. The FIFO decouples producer and consumer timing, breaks the EN-to-RDY combinational loop, and flags protocol violations. It is used wherever a generated Verilog module exposes a Put interface that must feed a Get interface on the same clock.

Parameters:
DATA_WIDTH, 32, payload width in bits (>=1)
DEPTH, 4, number of entries; power of two, >=2
PIPELINED, 0, 1 = RDY_put may assert while full if EN_get is asserted in the same cycle (enq+deq when full)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  reset; synchronous, active-high
put  input  DATA_WIDTH  enqueue data, sampled when EN_put && RDY_put
EN_put  input  1  enqueue enable; legal only when RDY_put=1
RDY_put  output  1  link can accept a put this cycle
get  output  DATA_WIDTH  head-of-queue data; valid when RDY_get=1
EN_get  input  1  dequeue enable; legal only when RDY_get=1
RDY_get  output  1  queue non-empty
count  output  $clog2(DEPTH+1)  current occupancy, registered
err_overflow  output  1  sticky; EN_put seen while RDY_put=0
err_underflow  output  1  sticky; EN_get seen while RDY_get=0

Behaviour:
- State: wr_ptr and rd_ptr, each $clog2(DEPTH) bits; count register; storage array DEPTH x DATA_WIDTH; two sticky error flags.
- Reset (RST=1 at a clock edge): wr_ptr=0, rd_ptr=0, count=0, err_* = 0. Storage contents are not reset. While RST is high, RDY_put=0 and RDY_get=0 combinationally, and EN_* are ignored with no error flagged. The first put is accepted in the first cycle with RST=0.
- Reset mid-operation discards all queued data. After reset, RDY_get=0 until a new put is accepted.
- full = (count==DEPTH); empty = (count==0).
- RDY_get = !empty && !RST. Registered-derived, no combinational input dependence.
- RDY_put:
  - PIPELINED=0: !full && !RST.
  - PIPELINED=1: (!full || EN_get) && !RST. This introduces the only combinational path, EN_get->RDY_put.
- get = storage[rd_ptr], continuously driven. When empty, get is don't-care; the bench must not check it.
- do_enq = EN_put && RDY_put; do_deq = EN_get && RDY_get.
- do_enq: storage[wr_ptr]<=put; wr_ptr<=wr_ptr+1, wrapping modulo DEPTH (natural wrap, power-of-two depth).
- do_deq: rd_ptr<=rd_ptr+1, wrapping modulo DEPTH.
- count: +1 on enq only, -1 on deq only, unchanged on both or neither.
- Latency: data accepted at edge N appears on get with RDY_get=1 in cycle N+1. There is no same-cycle bypass when empty.
- Simultaneous enq and deq:
  - When empty: only enq occurs, because RDY_get=0.
  - When full with PIPELINED=1: both occur, count stays DEPTH, and the new word lands in the slot just vacated (wr_ptr==rd_ptr).
- Protocol violations:
  - EN_put && !RDY_put: no state change; err_overflow<=1.
  - EN_get && !RDY_get: no state change; err_underflow<=1.
  - Both flags hold until RST.
- Throughput: one transfer per cycle in steady state on both sides.

Decomposition:
- Package get_put_link_pkg: function for pointer width ($clog2(DEPTH)), function for count width ($clog2(DEPTH+1)), and a localparam check helper asserting DEPTH is a power of two >=2 (elaboration-time error otherwise).
- One sub-module: get_put_link_mem. It holds DEPTH x DATA_WIDTH registers with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata). It has no reset.
- Pointer, count, and handshake logic stay in the top module.

Test Plan:
- Reset then idle: hold RST 3 cycles, release -> RDY_put=1, RDY_get=0, count=0, err_*=0. Assert EN_put during RST -> no error, count stays 0.
- Fill/drain, DEPTH=4, PIPELINED=0: put 0xA0..0xA3 on consecutive cycles -> count 1,2,3,4; RDY_put=0 after the 4th. Then get 4 times -> values 0xA0,0xA1,0xA2,0xA3 in order; RDY_get=0 and count=0 after.
- Wrap-around: push 10 sequential words with interleaved gets, keeping occupancy at 1-3 -> output sequence identical to input; pointers wrap twice with no loss.
- Full + simultaneous enq/deq:
  - PIPELINED=1: fill with 1..4, then assert EN_put=1 (put=5) and EN_get=1 in the same cycle -> RDY_put=1, get=1 consumed, count stays 4; subsequent gets return 2,3,4,5.
  - PIPELINED=0: same stimulus -> RDY_put=0, err_overflow=1, only the dequeue happens, count=3.
- Violations: EN_get while empty -> err_underflow=1, count stays 0, flag persists until RST.
- Reset mid-operation: with 3 entries queued, pulse RST 1 cycle -> next cycle count=0, RDY_get=0. A following put of 0x55 appears on get one cycle later.

Source files
------------

// File: rtl/get_put_link_fifo_pkg.sv
// Shared width helpers and the depth legality check for the get/put link FIFO.
package get_put_link_pkg;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // The pointers wrap naturally, so the depth must be a power of two of at least 2.
    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/get_put_link_fifo_if.sv
// Put/Get method bundle; the FIFO is the slave and the producer/consumer side is the master.
interface get_put_link_fifo_if
    import get_put_link_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [DATA_WIDTH-1:0] put;
    logic                  EN_put;
    logic                  RDY_put;
    logic [DATA_WIDTH-1:0] get;
    logic                  EN_get;
    logic                  RDY_get;
    logic [CW-1:0]         count;
    logic                  err_overflow;
    logic                  err_underflow;

    modport slave (
        input  put, EN_put, EN_get,
        output RDY_put, get, RDY_get, count, err_overflow, err_underflow
    );

    modport master (
        output put, EN_put, EN_get,
        input  RDY_put, get, RDY_get, count, err_overflow, err_underflow
    );
endinterface

// File: rtl/get_put_link_mem.sv
// Unreset register file: one synchronous write port, one asynchronous read port.
module get_put_link_mem
    import get_put_link_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [ptr_w(DEPTH)-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [ptr_w(DEPTH)-1:0]    raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/get_put_link_fifo.sv
// Buffered Put->Get link: DEPTH-entry register FIFO with sticky protocol-violation flags.
module get_put_link_fifo
    import get_put_link_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter bit          PIPELINED  = 1'b0
) (
    input  logic               CLK,
    input  logic               RST,
    get_put_link_fifo_if.slave link
);
    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    if (!depth_ok(DEPTH)) begin : g_depth_check
        $error("get_put_link_fifo: DEPTH must be a power of two >= 2");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          err_overflow_q;
    logic          err_underflow_q;
    logic          full;
    logic          empty;
    logic          rdy_put;
    logic          rdy_get;
    logic          do_enq;
    logic          do_deq;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == CW'(0));

    // EN_get -> RDY_put is the only combinational path, and only when pipelined.
    always_comb begin
        rdy_get = !empty && !RST;
        rdy_put = 1'b0;
        if (PIPELINED) begin
            rdy_put = (!full || link.EN_get) && !RST;
        end else begin
            rdy_put = !full && !RST;
        end
        do_enq = link.EN_put && rdy_put;
        do_deq = link.EN_get && rdy_get;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count_q         <= '0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_enq && !do_deq) begin
                count_q <= count_q + CW'(1);
            end else if (do_deq && !do_enq) begin
                count_q <= count_q - CW'(1);
            end
            if (link.EN_put && !rdy_put) begin
                err_overflow_q <= 1'b1;
            end
            if (link.EN_get && !rdy_get) begin
                err_underflow_q <= 1'b1;
            end
        end
    end

    get_put_link_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (CLK),
        .we    (do_enq),
        .waddr (wr_ptr),
        .wdata (link.put),
        .raddr (rd_ptr),
        .rdata (link.get)
    );

    assign link.RDY_put       = rdy_put;
    assign link.RDY_get       = rdy_get;
    assign link.count         = count_q;
    assign link.err_overflow  = err_overflow_q;
    assign link.err_underflow = err_underflow_q;
endmodule

// File: tb/tb_get_put_link_fifo.sv
// Directed bench for get_put_link_fifo: one non-pipelined and one pipelined instance on a shared clock/reset.
module tb_get_put_link_fifo;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    get_put_link_fifo_if #(.DATA_WIDTH(32), .DEPTH(4)) l0 ();
    get_put_link_fifo_if #(.DATA_WIDTH(32), .DEPTH(4)) l1 ();

    get_put_link_fifo #(.DATA_WIDTH(32), .DEPTH(4), .PIPELINED(1'b0)) u0 (
        .CLK (CLK), .RST (RST), .link (l0)
    );
    get_put_link_fifo #(.DATA_WIDTH(32), .DEPTH(4), .PIPELINED(1'b1)) u1 (
        .CLK (CLK), .RST (RST), .link (l1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] q[$];
    int          pushed;
    int          popped;
    logic        ep;
    logic        eg;

    initial begin
        l0.put = '0; l0.EN_put = 1'b0; l0.EN_get = 1'b0;
        l1.put = '0; l1.EN_put = 1'b0; l1.EN_get = 1'b0;

        // Reset held 3 cycles, with a put attempted during reset
        l0.put = 32'hEE; l0.EN_put = 1'b1;
        tick(); tick(); tick();
        check("rst_rdy_put", 64'(l0.RDY_put), 64'(0));
        check("rst_rdy_get", 64'(l0.RDY_get), 64'(0));
        check("rst_count", 64'(l0.count), 64'(0));
        check("rst_no_ovf", 64'(l0.err_overflow), 64'(0));
        l0.EN_put = 1'b0;
        RST = 1'b0;
        #1;
        check("idle_rdy_put", 64'(l0.RDY_put), 64'(1));
        check("idle_rdy_get", 64'(l0.RDY_get), 64'(0));
        check("idle_count", 64'(l0.count), 64'(0));
        check("idle_ovf", 64'(l0.err_overflow), 64'(0));
        check("idle_unf", 64'(l0.err_underflow), 64'(0));

        // Fill 0xA0..0xA3
        for (int i = 0; i < 4; i++) begin
            l0.put = 32'hA0 + 32'(i); l0.EN_put = 1'b1;
            tick();
            check("fill_count", 64'(l0.count), 64'(i + 1));
        end
        l0.EN_put = 1'b0;
        #1;
        check("full_rdy_put", 64'(l0.RDY_put), 64'(0));
        check("full_rdy_get", 64'(l0.RDY_get), 64'(1));

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            check("drain_data", 64'(l0.get), 64'(32'hA0 + 32'(i)));
            l0.EN_get = 1'b1;
            tick();
        end
        l0.EN_get = 1'b0;
        #1;
        check("drain_rdy_get", 64'(l0.RDY_get), 64'(0));
        check("drain_count", 64'(l0.count), 64'(0));
        check("drain_rdy_put", 64'(l0.RDY_put), 64'(1));

        // Wrap-around: 10 words, occupancy kept between 1 and 3
        pushed = 0; popped = 0;
        for (int c = 0; c < 40 && !(pushed == 10 && q.size() == 0); c++) begin
            ep = (pushed < 10) && (q.size() < 3);
            eg = (q.size() >= 2) || (pushed == 10 && q.size() > 0);
            if (eg) check("wrap_data", 64'(l0.get), 64'(q[0]));
            l0.put = 32'h100 + 32'(pushed); l0.EN_put = ep; l0.EN_get = eg;
            tick();
            if (eg) begin void'(q.pop_front()); popped++; end
            if (ep) begin q.push_back(32'h100 + 32'(pushed)); pushed++; end
            check("wrap_count", 64'(l0.count), 64'(q.size()));
        end
        l0.EN_put = 1'b0; l0.EN_get = 1'b0;
        check("wrap_popped", 64'(popped), 64'(10));
        check("wrap_ovf", 64'(l0.err_overflow), 64'(0));

        // Non-pipelined: put while full with a get in the same cycle
        for (int i = 1; i <= 4; i++) begin
            l0.put = 32'(i); l0.EN_put = 1'b1;
            tick();
        end
        l0.put = 32'd5; l0.EN_put = 1'b1; l0.EN_get = 1'b1;
        #1;
        check("p0_full_rdy_put", 64'(l0.RDY_put), 64'(0));
        check("p0_full_head", 64'(l0.get), 64'(1));
        tick();
        l0.EN_put = 1'b0; l0.EN_get = 1'b0;
        check("p0_ovf", 64'(l0.err_overflow), 64'(1));
        check("p0_count", 64'(l0.count), 64'(3));
        for (int i = 2; i <= 4; i++) begin
            check("p0_drain", 64'(l0.get), 64'(i));
            l0.EN_get = 1'b1;
            tick();
        end
        l0.EN_get = 1'b0;
        #1;
        check("p0_empty", 64'(l0.count), 64'(0));

        // Pipelined: put while full with a get in the same cycle
        for (int i = 1; i <= 4; i++) begin
            l1.put = 32'(i); l1.EN_put = 1'b1;
            tick();
        end
        l1.EN_put = 1'b0;
        #1;
        check("p1_full_rdy_put", 64'(l1.RDY_put), 64'(0));
        l1.put = 32'd5; l1.EN_put = 1'b1; l1.EN_get = 1'b1;
        #1;
        check("p1_comb_rdy_put", 64'(l1.RDY_put), 64'(1));
        check("p1_full_head", 64'(l1.get), 64'(1));
        tick();
        l1.EN_put = 1'b0; l1.EN_get = 1'b0;
        check("p1_count", 64'(l1.count), 64'(4));
        check("p1_ovf", 64'(l1.err_overflow), 64'(0));
        for (int i = 2; i <= 5; i++) begin
            check("p1_drain", 64'(l1.get), 64'(i));
            l1.EN_get = 1'b1;
            tick();
        end
        l1.EN_get = 1'b0;
        #1;
        check("p1_empty", 64'(l1.count), 64'(0));

        // Underflow on empty link is sticky
        l0.EN_get = 1'b1;
        tick();
        l0.EN_get = 1'b0;
        check("unf_set", 64'(l0.err_underflow), 64'(1));
        check("unf_count", 64'(l0.count), 64'(0));
        tick(); tick();
        check("unf_sticky", 64'(l0.err_underflow), 64'(1));
        check("unf_other_dut", 64'(l1.err_underflow), 64'(0));

        // Reset mid-operation with 3 entries queued
        for (int i = 0; i < 3; i++) begin
            l0.put = 32'h30 + 32'(i); l0.EN_put = 1'b1;
            tick();
        end
        l0.EN_put = 1'b0;
        check("mid_count", 64'(l0.count), 64'(3));
        RST = 1'b1;
        #1;
        check("mid_rst_rdy_get", 64'(l0.RDY_get), 64'(0));
        check("mid_rst_rdy_put", 64'(l0.RDY_put), 64'(0));
        tick();
        RST = 1'b0;
        check("mid_after_count", 64'(l0.count), 64'(0));
        check("mid_after_rdy_get", 64'(l0.RDY_get), 64'(0));
        check("mid_after_ovf", 64'(l0.err_overflow), 64'(0));
        check("mid_after_unf", 64'(l0.err_underflow), 64'(0));
        l0.put = 32'h55; l0.EN_put = 1'b1;
        #1;
        check("no_bypass", 64'(l0.RDY_get), 64'(0));
        tick();
        l0.EN_put = 1'b0;
        check("post_rst_rdy_get", 64'(l0.RDY_get), 64'(1));
        check("post_rst_data", 64'(l0.get), 64'(32'h55));
        check("post_rst_count", 64'(l0.count), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
